// File: rtl/stream_arbiter.sv
// -----------------------------------------------------------------------------
// stream_arbiter
//
// Shares one downstream valid/ready channel between NUM_REQ upstream
// requesters (fetch, load/store, debug, ...). Arbitration is round-robin with
// burst locking: a requester that wins keeps the grant until it hands over a
// beat with input_last=1. The output side is a single registered beat so the
// downstream port sees clean flop outputs.
//
// Ports:
//   clk            clock, everything on posedge
//   reset          synchronous, active-high
//   input_valid    [NUM_REQ]        per-requester valid
//   input_ready    [NUM_REQ]        per-requester ready (combinational, onehot0)
//   input_data     [NUM_REQ*WIDTH]  requester i payload at [i*WIDTH +: WIDTH]
//   input_last     [NUM_REQ]        per-requester end-of-burst flag
//   output_valid   registered valid towards downstream
//   output_ready   downstream ready
//   output_data    [WIDTH]  registered payload
//   output_last    registered last flag of the held beat
//   output_source  [SRC_W]  index of the requester that produced the held beat
// -----------------------------------------------------------------------------
module stream_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       input_valid,
  output logic [NUM_REQ-1:0]       input_ready,
  input  logic [NUM_REQ*WIDTH-1:0] input_data,
  input  logic [NUM_REQ-1:0]       input_last,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [WIDTH-1:0]         output_data,
  output logic                     output_last,
  output logic [SRC_W-1:0]         output_source
);

  // UNLOCKED: free arbitration from rr_ptr. LOCKED: owner holds the grant.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t             state_reg,      state_next;
  logic [SRC_W-1:0]   owner_reg,      owner_next;
  logic [SRC_W-1:0]   rr_ptr_reg,     rr_ptr_next;
  logic               out_valid_reg,  out_valid_next;
  logic [WIDTH-1:0]   out_data_reg,   out_data_next;
  logic               out_last_reg,   out_last_next;
  logic [SRC_W-1:0]   out_source_reg, out_source_next;

  logic [WIDTH-1:0]   req_data [NUM_REQ];
  logic               has_pick;
  logic [SRC_W-1:0]   pick;
  logic [SRC_W:0]     scan_idx;
  logic               can_load;
  logic               accept;

  // Per-requester payload slices, so the mux below is a plain array index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_data[gi] = input_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Candidate selection. While locked the owner is the only candidate even
  // if its valid is low, which is what lets a burst contain bubbles without
  // losing the grant. Unlocked, scan forward from rr_ptr with wrap-around;
  // the !has_pick guard keeps the first hit.
  always_comb begin
    has_pick = 1'b0;
    pick     = '0;
    scan_idx = '0;
    if (state_reg == LOCKED) begin
      has_pick = 1'b1;
      pick     = owner_reg;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
        if (scan_idx >= (SRC_W+1)'(NUM_REQ)) begin
          scan_idx = scan_idx - (SRC_W+1)'(NUM_REQ);
        end
        if (!has_pick && input_valid[scan_idx[SRC_W-1:0]]) begin
          has_pick = 1'b1;
          pick     = scan_idx[SRC_W-1:0];
        end
      end
    end
  end

  // The output stage can take a beat when it is empty or draining this cycle.
  assign can_load = !out_valid_reg || output_ready;

  // Ready goes only to the picked requester; reset forces every ready low so
  // nothing is handed over while the block is being cleared.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign input_ready[gi] = !reset && can_load && has_pick &&
                               (pick == SRC_W'(gi));
    end
  endgenerate

  assign accept = |(input_valid & input_ready);

  // Next-state / output-stage logic.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    rr_ptr_next     = rr_ptr_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_last_next   = out_last_reg;
    out_source_next = out_source_reg;

    if (accept) begin
      // Load replaces any beat draining on the same edge, so back-to-back
      // beats flow at one per cycle.
      out_valid_next  = 1'b1;
      out_data_next   = req_data[pick];
      out_last_next   = input_last[pick];
      out_source_next = pick;
      if (input_last[pick]) begin
        // Single beat or end of burst: release and move priority past pick.
        state_next  = UNLOCKED;
        rr_ptr_next = (pick == SRC_W'(NUM_REQ-1)) ? '0 : pick + SRC_W'(1);
      end else begin
        state_next = LOCKED;
        owner_next = pick;
      end
    end else if (output_ready) begin
      out_valid_next = 1'b0;
    end
    // Otherwise the beat is held untouched under backpressure.
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= UNLOCKED;
      owner_reg      <= '0;
      rr_ptr_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_source_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      rr_ptr_reg     <= rr_ptr_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_last_reg   <= out_last_next;
      out_source_reg <= out_source_next;
    end
  end

  assign output_valid  = out_valid_reg;
  assign output_data   = out_data_reg;
  assign output_last   = out_last_reg;
  assign output_source = out_source_reg;

`ifdef FORMAL
  // Upstream contract: a stalled requester keeps valid, data and last.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_assume
      am_hold: assume property (@(posedge clk) disable iff (reset)
        (input_valid[gi] && !input_ready[gi]) |=>
          (input_valid[gi] && $stable(input_data[gi*WIDTH +: WIDTH]) &&
           $stable(input_last[gi])));
    end
  endgenerate

  ap_onehot_ready: assert property (@(posedge clk)
    $onehot0(input_ready));

  ap_out_stable: assert property (@(posedge clk) disable iff (reset)
    (output_valid && !output_ready) |=>
      (output_valid && $stable(output_data) && $stable(output_last) &&
       $stable(output_source)));

  ap_lock_owner_only: assert property (@(posedge clk) disable iff (reset)
    (state_reg == LOCKED) |->
      ((input_valid & input_ready & ~(NUM_REQ'(1) << owner_reg)) == '0));

  ap_source_match: assert property (@(posedge clk) disable iff (reset)
    accept |=> (output_valid && output_source == $past(pick)));
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_arbiter
//
// Each requester owns a queue of beats. A requester presents the head of its
// queue (randomly or forced) and, once presented, holds it until accepted.
// A transaction-level reference model decides each cycle who should be
// granted (owner while a burst is open, otherwise the first valid requester
// from the round-robin pointer), and what the registered output must show.
// Directed scenarios check the headline behaviours with fixed constants,
// followed by a long randomized run against the same model.
// -----------------------------------------------------------------------------
module tb_stream_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       input_valid;
  logic [NUM_REQ-1:0]       input_ready;
  logic [NUM_REQ*WIDTH-1:0] input_data;
  logic [NUM_REQ-1:0]       input_last;
  logic                     output_valid;
  logic                     output_ready;
  logic [WIDTH-1:0]         output_data;
  logic                     output_last;
  logic [SRC_W-1:0]         output_source;

  stream_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .output_source(output_source)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus: per-requester beat queues ({last, data}) and presented beat.
  logic [WIDTH:0]   beats [NUM_REQ][$];
  bit               cur_v [NUM_REQ];
  bit               cur_l [NUM_REQ];
  logic [WIDTH-1:0] cur_d [NUM_REQ];

  // Reference model state.
  bit               m_locked;
  int               m_owner;
  int               m_rr;
  bit               m_ov;
  bit               m_ol;
  logic [WIDTH-1:0] m_od;
  int               m_os;

  int                 accepted_from;
  logic [NUM_REQ-1:0] obs_ready;

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      input_valid[i]                = cur_v[i];
      input_last[i]                 = cur_l[i];
      input_data[i*WIDTH +: WIDTH]  = cur_d[i];
    end
  endtask

  task automatic add_beat(input int r, input bit last, input logic [WIDTH-1:0] d);
    beats[r].push_back({last, d});
  endtask

  // Present queue heads for requesters in mask with probability prob percent.
  task automatic present(input int prob, input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i] && !cur_v[i] && beats[i].size() > 0 &&
          $urandom_range(0, 99) < prob) begin
        cur_v[i] = 1'b1;
        {cur_l[i], cur_d[i]} = beats[i][0];
      end
    end
    apply_inputs();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NUM_REQ; i++) begin
      beats[i].delete();
      cur_v[i] = 1'b0;
      cur_l[i] = 1'b0;
      cur_d[i] = '0;
    end
    apply_inputs();
  endtask

  // One clock cycle: check ready against the model, advance the model,
  // clock the DUT, check the registered output, retire the accepted beat.
  task automatic step(input bit rdy);
    int                 pick;
    bit                 can_load;
    logic [NUM_REQ-1:0] exp_ready;
    output_ready = rdy;
    #1;
    pick = -1;
    if (!reset) begin
      if (m_locked) pick = m_owner;
      else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (pick < 0 && cur_v[(m_rr + k) % NUM_REQ]) pick = (m_rr + k) % NUM_REQ;
        end
      end
    end
    can_load  = !m_ov || rdy;
    exp_ready = '0;
    if (pick >= 0 && can_load) exp_ready[pick] = 1'b1;
    obs_ready = input_ready;
    check("input_ready", input_ready, exp_ready);

    accepted_from = -1;
    if (pick >= 0 && can_load && cur_v[pick]) accepted_from = pick;

    if (reset) begin
      m_locked = 0; m_owner = 0; m_rr = 0;
      m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
    end else if (accepted_from >= 0) begin
      m_ov = 1; m_od = cur_d[pick]; m_ol = cur_l[pick]; m_os = pick;
      if (cur_l[pick]) begin
        m_locked = 0;
        m_rr     = (pick + 1) % NUM_REQ;
      end else begin
        m_locked = 1;
        m_owner  = pick;
      end
    end else if (rdy) begin
      m_ov = 0;
    end

    @(posedge clk);
    #1;
    check("output_valid", output_valid, m_ov);
    check("output_data", output_data, m_od);
    check("output_last", output_last, m_ol);
    check("output_source", output_source, m_os);

    if (accepted_from >= 0) begin
      void'(beats[accepted_from].pop_front());
      cur_v[accepted_from] = 1'b0;
    end
    apply_inputs();
  endtask

  task automatic do_reset();
    clear_stim();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  int exp_seq [5] = '{2, 2, 2, 3, 0};

  initial begin
    reset        = 1'b1;
    output_ready = 1'b0;
    input_valid  = '0;
    input_last   = '0;
    input_data   = '0;
    clear_stim();

    // Reset state.
    do_reset();
    check("reset_valid", output_valid, 1'b0);
    check("reset_source", output_source, '0);

    // Single requester; then rr_ptr must have moved to 2.
    add_beat(1, 1'b1, 32'hA5A5_0001);
    present(100, 4'b0010);
    step(1'b1);
    check("single_valid", output_valid, 1'b1);
    check("single_data", output_data, 32'hA5A5_0001);
    check("single_src", output_source, 2'd1);
    check("single_last", output_last, 1'b1);
    add_beat(0, 1'b1, 32'h0000_0A00);
    add_beat(2, 1'b1, 32'h0000_0A02);
    present(100, 4'b0101);
    step(1'b1);
    check("rr_after_1", accepted_from, 2);

    // Fairness: all valid, single beats, no bubbles.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 3; j++) add_beat(i, 1'b1, 32'(i * 16 + j));
    for (int c = 0; c < 12; c++) begin
      present(100, 4'b1111);
      step(1'b1);
      check("fair_src", accepted_from, c % NUM_REQ);
    end

    // Burst lock: req2 three beats while req0/req3 wait.
    do_reset();
    add_beat(1, 1'b1, 32'h1111);
    present(100, 4'b0010);
    step(1'b1);
    add_beat(2, 1'b0, 32'h2000);
    add_beat(2, 1'b0, 32'h2001);
    add_beat(2, 1'b1, 32'h2002);
    add_beat(0, 1'b1, 32'h0000);
    add_beat(3, 1'b1, 32'h3000);
    for (int c = 0; c < 5; c++) begin
      present(100, 4'b1101);
      step(1'b1);
      check("burst_src", accepted_from, exp_seq[c]);
      if (c < 3) check("burst_rdy03", obs_ready & 4'b1001, 4'b0000);
    end

    // Backpressure: held beat stays stable, no loss on release.
    do_reset();
    add_beat(0, 1'b1, 32'h1234);
    add_beat(0, 1'b1, 32'h5678);
    present(100, 4'b0001);
    step(1'b1);
    for (int c = 0; c < 5; c++) begin
      present(100, 4'b0001);
      step(1'b0);
      check("bp_data", output_data, 32'h1234);
      check("bp_rdy", obs_ready, 4'b0000);
    end
    step(1'b1);
    check("bp_next", output_data, 32'h5678);
    check("bp_empty", beats[0].size(), 0);
    step(1'b1);
    check("bp_drained", output_valid, 1'b0);

    // Lock with bubble: req1 opens a burst and goes quiet, req2 must wait.
    do_reset();
    add_beat(1, 1'b0, 32'hB100);
    present(100, 4'b0010);
    step(1'b1);
    add_beat(2, 1'b1, 32'hB200);
    for (int c = 0; c < 3; c++) begin
      present(100, 4'b0100);
      step(1'b1);
      check("bubble_none", accepted_from, -1);
    end
    add_beat(1, 1'b1, 32'hB101);
    present(100, 4'b0110);
    step(1'b1);
    check("bubble_own", accepted_from, 1);
    step(1'b1);
    check("bubble_next", accepted_from, 2);

    // Reset mid-burst: pending beat dropped, fresh arbitration afterwards.
    do_reset();
    add_beat(0, 1'b0, 32'hC000);
    add_beat(0, 1'b1, 32'hC001);
    add_beat(3, 1'b1, 32'hC300);
    present(100, 4'b0001);
    step(1'b0);
    check("mid_valid", output_valid, 1'b1);
    reset = 1'b1;
    step(1'b0);
    check("mid_rst", output_valid, 1'b0);
    reset = 1'b0;
    present(100, 4'b1001);
    step(1'b1);
    check("mid_regrant", accepted_from, 0);

    // Randomized traffic with random backpressure and bubbles.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      int nb;
      nb = 40 + $urandom_range(0, 20);
      for (int j = 0; j < nb; j++)
        add_beat(i, (j == nb - 1) || ($urandom_range(0, 99) < 35), $urandom);
    end
    for (int c = 0; c < 600; c++) begin
      present(60, 4'b1111);
      step($urandom_range(0, 99) < 70);
    end
    for (int c = 0; c < 2000; c++) begin
      if (beats[0].size() + beats[1].size() + beats[2].size() + beats[3].size() == 0)
        break;
      present(100, 4'b1111);
      step(1'b1);
    end
    check("drain_empty",
          beats[0].size() + beats[1].size() + beats[2].size() + beats[3].size(), 0);
    step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
